sb_stream_initiator: RTL and testbench

//  RTL-side originator for the switchboard stream loop: generates a numbered burst of 256-bit packets
//  on an SB TX port and consumes the modified packets returning on an SB RX port. Each returned

---
 rtl/sb_stream_pkg.sv | 22 ++
 rtl/sb_stream_if.sv | 31 +++
 rtl/sb_stream_fifo.sv | 56 +++++
 rtl/sb_stream_initiator.sv | 193 +++++++++++++++++++
 tb/tb_sb_stream_initiator.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/sb_stream_pkg.sv
// Shared types and constants for the switchboard stream initiator.
// Optional watchdog: define SB_STREAM_TIMEOUT_EN to enable it in sb_stream_initiator.
package sb_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [63:0] DEFAULT_INCR = 64'd42;
    localparam int          PAYLOAD_W    = 64;

    // Value the responder is expected to return for a given sent payload.
    function automatic logic [PAYLOAD_W-1:0] expected_return(
        input logic [PAYLOAD_W-1:0] payload,
        input logic [PAYLOAD_W-1:0] incr
    );
        return payload + incr;
    endfunction

endpackage

// File: rtl/sb_stream_if.sv
// Switchboard TX/RX stream bundle. The master is the originator of TX packets
// and the consumer of returned RX packets; the slave is the loop responder.
interface sb_stream_if #(
    parameter int DW = 256
) ();
    logic [DW-1:0] tx_data;
    logic [31:0]   tx_dest;
    logic          tx_last;
    logic          tx_valid;
    logic          tx_ready;

    logic [DW-1:0] rx_data;
    logic [31:0]   rx_dest;
    logic          rx_last;
    logic          rx_valid;
    logic          rx_ready;

    modport master (
        output tx_data, tx_dest, tx_last, tx_valid,
        input  tx_ready,
        input  rx_data, rx_dest, rx_last, rx_valid,
        output rx_ready
    );

    modport slave (
        input  tx_data, tx_dest, tx_last, tx_valid,
        output tx_ready,
        output rx_data, rx_dest, rx_last, rx_valid,
        input  rx_ready
    );
endinterface

// File: rtl/sb_stream_fifo.sv
// Synchronous FIFO holding the expected return value of every packet in flight.
// DEPTH must be a power of two (>= 2). Flush empties it in one cycle.
module sb_stream_fifo
    import sb_stream_pkg::*;
#(
    parameter int WIDTH = PAYLOAD_W,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    // Pointer and occupancy tracking; push and pop in one cycle leave the count unchanged.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are only read while the FIFO is non-empty, so no reset.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/sb_stream_initiator.sv
// Initiator end of the switchboard stream-modifier loop: sends a numbered burst of
// packets, checks that each returned packet carries payload + INCR, and reports
// completion. Optional idle watchdog enabled by defining SB_STREAM_TIMEOUT_EN.
module sb_stream_initiator
    import sb_stream_pkg::*;
#(
    parameter int          DW      = 256,
    parameter int          CNT_W   = 32,
    parameter int          DEPTH   = 8,
    parameter logic [63:0] INCR    = DEFAULT_INCR,
    parameter int          TMO_CYC = 1024
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_pkts,
    input  logic [63:0]      seed,
    input  logic [31:0]      dest_in,
    sb_stream_if.master      sb,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] rx_count,
    output logic             timeout
);
    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_k;
    logic [63:0]      r_payload;
    logic [31:0]      r_dest;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [CNT_W-1:0] r_err_count;
    logic [CNT_W-1:0] r_rx_count;

    logic             w_start_acc;
    logic             w_tx_valid;
    logic             w_tx_hs;
    logic             w_rx_hs;
    logic             w_pop;
    logic             w_bad_rx;
    logic             w_full;
    logic             w_empty;
    logic             w_flush;
    logic             w_tmo_hit;
    logic [63:0]      w_head;
    logic [DW-1:0]    w_tx_data;
    logic             w_unused_rx;

    // start is only honoured outside a burst; tx_valid depends on registered state only.
    assign w_start_acc = start && (r_state != RUN);
    assign w_tx_valid  = (r_state == RUN) && (r_k < r_num) && !w_full;
    assign w_tx_hs     = w_tx_valid && sb.tx_ready;
    assign w_rx_hs     = (r_state == RUN) && sb.rx_valid;
    assign w_pop       = w_rx_hs && !w_empty;
    assign w_bad_rx    = w_rx_hs && (w_empty || (sb.rx_data[63:0] != w_head));
    assign w_flush     = w_start_acc || w_tmo_hit;

    sb_stream_fifo #(
        .WIDTH (PAYLOAD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .nreset      (nreset),
        .i_flush     (w_flush),
        .i_push      (w_tx_hs),
        .i_push_data (expected_return(r_payload, INCR)),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

`ifdef SB_STREAM_TIMEOUT_EN
    localparam int WD_W = $clog2(TMO_CYC + 1);
    logic [WD_W-1:0] r_wdog;
    logic            r_timeout;

    assign w_tmo_hit = (r_state == RUN) && !w_empty && !w_rx_hs &&
                       (r_wdog == WD_W'(TMO_CYC - 1));

    // Watchdog: counts stalled RUN cycles with packets outstanding; any return restarts it.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else if (w_start_acc) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else if ((r_state != RUN) || w_rx_hs) begin
            r_wdog    <= '0;
        end else if (w_tmo_hit) begin
            r_wdog    <= '0;
            r_timeout <= 1'b1;
        end else if (!w_empty) begin
            r_wdog    <= r_wdog + WD_W'(1);
        end
    end

    assign timeout = r_timeout;
`else
    localparam int unused_tmo_cyc = TMO_CYC;
    assign w_tmo_hit = 1'b0;
    assign timeout   = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!nreset) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    // FSM next state: a burst ends once every packet is sent and every return is matched.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) w_state_next = (num_pkts == '0) ? DONE : RUN;
                else       w_state_next = r_state;
            end
            RUN: begin
                if (w_tmo_hit)                        w_state_next = DONE;
                else if ((r_k == r_num) && w_empty)   w_state_next = DONE;
                else                                  w_state_next = RUN;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Burst datapath: latched parameters, sent counter, payload and return statistics.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_num       <= '0;
            r_k         <= '0;
            r_payload   <= 64'd0;
            r_dest      <= 32'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= '0;
            r_rx_count  <= '0;
        end else begin
            r_busy <= (w_state_next == RUN);
            r_done <= (w_state_next == DONE);
            if (w_start_acc) begin
                r_num       <= num_pkts;
                r_k         <= '0;
                r_payload   <= seed;
                r_dest      <= dest_in;
                r_err       <= 1'b0;
                r_err_count <= '0;
                r_rx_count  <= '0;
            end else begin
                if (w_tx_hs) begin
                    r_k       <= r_k + CNT_W'(1);
                    r_payload <= r_payload + 64'd1;
                end
                if (w_rx_hs) begin
                    r_rx_count <= r_rx_count + CNT_W'(1);
                end
                if (w_bad_rx) begin
                    r_err <= 1'b1;
                    if (r_err_count != {CNT_W{1'b1}}) r_err_count <= r_err_count + CNT_W'(1);
                end
                if (w_tmo_hit) r_err <= 1'b1;
            end
        end
    end

    // Only the low 64 bits carry payload; upper data bits are always zero.
    always_comb begin
        w_tx_data        = '0;
        w_tx_data[63:0]  = r_payload;
    end

    // Returned dest/last and upper data bits carry nothing this block checks.
    assign w_unused_rx = ^{sb.rx_dest, sb.rx_last, sb.rx_data};

    assign sb.tx_data  = w_tx_data;
    assign sb.tx_dest  = r_dest;
    assign sb.tx_last  = 1'b1;
    assign sb.tx_valid = w_tx_valid;
    assign sb.rx_ready = r_busy;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign err_count   = r_err_count;
    assign rx_count    = r_rx_count;

endmodule

// File: tb/tb_sb_stream_initiator.sv
// Randomized bench for sb_stream_initiator: the bench plays the loop responder
// and predicts every observable result from the burst rules.
module tb_sb_stream_initiator;
    localparam int DEPTH = 8;
    localparam int TMO   = 1024;

    logic        clk;
    logic        nreset;
    logic        start;
    logic [31:0] num_pkts;
    logic [63:0] seed;
    logic [31:0] dest_in;
    logic        busy, done, err, timeout;
    logic [31:0] err_count, rx_count;
    int          n_checks;
    int          n_fail;

    sb_stream_if #(.DW(256)) u_if ();

    sb_stream_initiator #(
        .DW(256), .CNT_W(32), .DEPTH(DEPTH), .INCR(64'd42), .TMO_CYC(TMO)
    ) u_dut (
        .clk(clk), .nreset(nreset), .start(start), .num_pkts(num_pkts),
        .seed(seed), .dest_in(dest_in), .sb(u_if.master),
        .busy(busy), .done(done), .err(err), .err_count(err_count),
        .rx_count(rx_count), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_tx_valid"}, u_if.tx_valid, 1'b0);
        check_eq({tag, "_rx_ready"}, u_if.rx_ready, 1'b0);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_done"}, done, 1'b0);
        check_eq({tag, "_err"}, err, 1'b0);
        check_eq({tag, "_err_count"}, err_count, 64'd0);
        check_eq({tag, "_rx_count"}, rx_count, 64'd0);
        check_eq({tag, "_timeout"}, timeout, 1'b0);
        check_eq({tag, "_tx_data"}, u_if.tx_data[63:0], 64'd0);
        check_eq({tag, "_tx_dest"}, u_if.tx_dest, 64'd0);
    endtask

    task automatic rand_rx(input logic [63:0] low, output logic [255:0] v);
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        v[63:0] = low;
    endtask

    // One burst: responder returns payload+42 (41 on packet 'bad'), silent for 'hold' cycles.
    task automatic run_burst(input logic [63:0] sd, input int n, input int bad, input int hold,
                             input int rdy_pct, input int rx_pct, input bit exp_tmo);
        logic [63:0]  sent_q[$];
        logic [31:0]  dst;
        logic [255:0] rxv;
        logic [63:0]  ret;
        int k, nrx, cyc, k_hold;
        bit tx_go, pres;
        dst = $urandom();
        start = 1'b1; num_pkts = n; seed = sd; dest_in = dst;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0; nrx = 0; cyc = 0; k_hold = -1;
        while (done !== 1'b1 && cyc < 4000) begin
            if (cyc == hold) k_hold = k;
            check_eq("busy_run", busy, 1'b1);
            check_eq("tx_valid_rule", u_if.tx_valid, (k < n) && (k - nrx < DEPTH));
            u_if.tx_ready = ($urandom_range(99) < rdy_pct);
            tx_go = u_if.tx_valid && u_if.tx_ready;
            if (tx_go) begin
                check_eq("tx_payload", u_if.tx_data[63:0], sd + 64'(k));
                check_eq("tx_upper_zero", {63'd0, |u_if.tx_data[255:64]}, 64'd0);
            end
            pres = (cyc >= hold) && (sent_q.size() > 0) && ($urandom_range(99) < rx_pct);
            ret  = pres ? sent_q[0] + ((nrx == bad) ? 64'd41 : 64'd42) : 64'(($urandom()));
            rand_rx(ret, rxv);
            u_if.rx_valid = pres;
            u_if.rx_data  = rxv;
            u_if.rx_dest  = $urandom();
            u_if.rx_last  = 1'($urandom());
            if (pres && u_if.rx_ready) begin
                void'(sent_q.pop_front());
                nrx++;
            end
            if (tx_go) begin
                sent_q.push_back(sd + 64'(k));
                k++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        u_if.rx_valid = 1'b0;
        u_if.tx_ready = 1'b0;
        check_eq("done", done, 1'b1);
        check_eq("busy_end", busy, 1'b0);
        check_eq("tx_valid_end", u_if.tx_valid, 1'b0);
        check_eq("rx_ready_end", u_if.rx_ready, 1'b0);
        check_eq("tx_last", u_if.tx_last, 1'b1);
        check_eq("tx_dest", u_if.tx_dest, dst);
        check_eq("err", err, ((bad >= 0) && (bad < n)) || exp_tmo);
        check_eq("timeout", timeout, exp_tmo);
        check_eq("rx_count", rx_count, exp_tmo ? 0 : n);
        if (!exp_tmo) begin
            check_eq("tx_count", k, n);
            check_eq("err_count", err_count, ((bad >= 0) && (bad < n)) ? 1 : 0);
        end else begin
            check_eq("tmo_latency", (cyc >= TMO) && (cyc <= TMO + 16), 1'b1);
        end
        if (n == 0) check_eq("zero_done_latency", cyc, 0);
        if (hold > 0 && hold < 4000) check_eq("tx_before_rx", k_hold, DEPTH);
    endtask

    initial begin
        logic [255:0] junk;
        int n;
        n_checks = 0; n_fail = 0;
        nreset = 1'b0; start = 1'b0; num_pkts = '0; seed = '0; dest_in = '0;
        u_if.tx_ready = 1'b0; u_if.rx_valid = 1'b0; u_if.rx_data = '0;
        u_if.rx_dest = '0; u_if.rx_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        nreset = 1'b1;
        @(posedge clk); #1;

        run_burst(64'd0, 5, -1, 0, 100, 100, 1'b0);
        run_burst(64'd0, 5, 2, 0, 100, 100, 1'b0);
        run_burst(64'h1234, 20, -1, 20, 100, 100, 1'b0);
        run_burst(64'hFFFF_FFFF_FFFF_FFFE, 3, -1, 0, 100, 100, 1'b0);

        run_burst(64'd7, 0, -1, 0, 100, 100, 1'b0);
        rand_rx(64'd49, junk);
        u_if.rx_data = junk; u_if.rx_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check_eq("zero_rx_ready", u_if.rx_ready, 1'b0);
            check_eq("zero_rx_count", rx_count, 64'd0);
            check_eq("zero_err", err, 1'b0);
        end
        u_if.rx_valid = 1'b0;

        start = 1'b1; num_pkts = 10; seed = 64'h55; dest_in = 32'hABCD;
        @(posedge clk); #1;
        start = 1'b0; u_if.tx_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        nreset = 1'b0; u_if.tx_ready = 1'b0;
        @(posedge clk); #1;
        check_cleared("midreset");
        nreset = 1'b1;
        rand_rx(64'h55 + 64'd42, junk);
        u_if.rx_data = junk; u_if.rx_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check_eq("post_reset_rx_ready", u_if.rx_ready, 1'b0);
            check_eq("post_reset_rx_count", rx_count, 64'd0);
        end
        u_if.rx_valid = 1'b0;
        run_burst(64'h99, 6, -1, 0, 100, 100, 1'b0);

        repeat (6) begin
            n = $urandom_range(1, 30);
            run_burst({$urandom(), $urandom()}, n,
                      ($urandom_range(2) == 0) ? $urandom_range(0, n - 1) : -1,
                      0, $urandom_range(30, 100), $urandom_range(30, 100), 1'b0);
        end

`ifdef SB_STREAM_TIMEOUT_EN
        run_burst(64'd100, 4, -1, 1000000, 100, 100, 1'b1);
        run_burst(64'd200, 4, -1, 0, 100, 100, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
